// File: rtl/mem_port_arbiter.sv
// Arbitrates the IF and MA ports onto the byte-wide memory bus and serialises 1/2/4-byte accesses.
// Define ARB_RR_EN for round-robin arbitration; otherwise MA has fixed priority over IF.
module mem_port_arbiter #(
  parameter int unsigned MEM_A_BITS = 18,
  parameter int unsigned IF_BYTES   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        ma_req,
  input  logic        ma_we,
  input  logic [1:0]  ma_width,
  input  logic [31:0] ma_addr,
  input  logic [31:0] ma_wdata,
  output logic [31:0] ma_rdata,
  output logic        ma_done,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  localparam logic [31:0] AddrMask = (MEM_A_BITS >= 32) ? 32'hffff_ffff :
                                     ((32'd1 << MEM_A_BITS) - 32'd1);
  localparam logic [2:0]  IfLen    = (IF_BYTES == 2) ? 3'd2 : 3'd4;

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e      state_q;
  logic        is_ma_q, pend_q, stall_q, mem_wr_q, if_done_q, ma_done_q;
  logic [2:0]  len_q, cnt_q, cap_q;
  logic [31:0] addr_q, wdata_q, rbuf_q, reread_a_q, mem_a_q;
  logic [31:0] if_rdata_q, ma_rdata_q;
  logic [7:0]  mem_dout_q;
`ifdef ARB_RR_EN
  logic        last_ma_q;
`endif

  logic        grant_ma, grant_if, capture, last_cap;
  logic [2:0]  ma_len, rd_idx;
  logic [31:0] grant_addr, rbuf_new;

  always_comb begin
`ifdef ARB_RR_EN
    grant_ma = ma_req & (~if_req | ~last_ma_q);
`else
    grant_ma = ma_req;
`endif
    grant_if   = if_req & ~grant_ma;
    grant_addr = grant_ma ? ma_addr : if_addr;
    case (ma_width)
      2'b00:   ma_len = 3'd1;
      2'b01:   ma_len = 3'd2;
      default: ma_len = 3'd4;
    endcase
    // After a stall the in-flight byte is lost, so restart issue at the first uncaptured byte.
    rd_idx   = stall_q ? cap_q : cnt_q;
    capture  = pend_q & ~stall_q;
    last_cap = capture & (cap_q == len_q - 3'd1);
    rbuf_new = rbuf_q;
    if (capture) rbuf_new[{cap_q[1:0], 3'b000} +: 8] = mem_din;
  end

  assign mem_a    = (state_q == StRead && stall_q) ? reread_a_q : mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr   = mem_wr_q & rdy;
  assign if_done  = if_done_q & rdy;
  assign ma_done  = ma_done_q & rdy;
  assign if_rdata = if_rdata_q;
  assign ma_rdata = ma_rdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      is_ma_q    <= 1'b0;
      pend_q     <= 1'b0;
      stall_q    <= 1'b0;
      mem_wr_q   <= 1'b0;
      if_done_q  <= 1'b0;
      ma_done_q  <= 1'b0;
      len_q      <= 3'd0;
      cnt_q      <= 3'd0;
      cap_q      <= 3'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rbuf_q     <= 32'd0;
      reread_a_q <= 32'd0;
      mem_a_q    <= 32'd0;
      if_rdata_q <= 32'd0;
      ma_rdata_q <= 32'd0;
      mem_dout_q <= 8'd0;
`ifdef ARB_RR_EN
      last_ma_q  <= 1'b0;
`endif
    end else begin
      stall_q <= ~rdy;
      if (rdy) begin
        case (state_q)
          StIdle: begin
            if (grant_ma || grant_if) begin
              is_ma_q    <= grant_ma;
              addr_q     <= grant_addr;
              len_q      <= grant_ma ? ma_len : IfLen;
              wdata_q    <= ma_wdata;
              mem_a_q    <= grant_addr & AddrMask;
              reread_a_q <= grant_addr & AddrMask;
              cap_q      <= 3'd0;
              pend_q     <= 1'b0;
              rbuf_q     <= 32'd0;
`ifdef ARB_RR_EN
              last_ma_q  <= grant_ma;
`endif
              if (grant_ma && ma_we) begin
                mem_dout_q <= ma_wdata[7:0];
                mem_wr_q   <= 1'b1;
                cnt_q      <= 3'd1;
                state_q    <= StWrite;
              end else begin
                cnt_q   <= 3'd0;
                state_q <= StRead;
              end
            end
          end
          StRead: begin
            if (capture) begin
              rbuf_q     <= rbuf_new;
              cap_q      <= cap_q + 3'd1;
              reread_a_q <= (addr_q + 32'(cap_q) + 32'd1) & AddrMask;
            end
            if (last_cap) begin
              state_q <= StDone;
              pend_q  <= 1'b0;
              if (is_ma_q) begin
                ma_rdata_q <= rbuf_new;
                ma_done_q  <= 1'b1;
              end else begin
                if_rdata_q <= rbuf_new;
                if_done_q  <= 1'b1;
              end
            end else if (rd_idx < len_q) begin
              pend_q  <= 1'b1;
              cnt_q   <= rd_idx + 3'd1;
              mem_a_q <= (addr_q + 32'(rd_idx) + 32'd1) & AddrMask;
            end else begin
              pend_q <= 1'b0;
            end
          end
          StWrite: begin
            if (cnt_q == len_q) begin
              state_q   <= StDone;
              mem_wr_q  <= 1'b0;
              ma_done_q <= 1'b1;
            end else begin
              mem_a_q    <= (addr_q + 32'(cnt_q)) & AddrMask;
              mem_dout_q <= wdata_q[{cnt_q[1:0], 3'b000} +: 8];
              cnt_q      <= cnt_q + 3'd1;
            end
          end
          StDone: begin
            state_q   <= StIdle;
            if_done_q <= 1'b0;
            ma_done_q <= 1'b0;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized single-port
// transactions scored against a byte-array memory model and transaction-level timing rules.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int unsigned ABits = 18;
  localparam logic [31:0] AMask = 32'h0003_ffff;
  localparam int          IfN   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        ma_req = 1'b0;
  logic        ma_we = 1'b0;
  logic [1:0]  ma_width = 2'b00;
  logic [31:0] ma_addr = 32'd0;
  logic [31:0] ma_wdata = 32'd0;
  logic [31:0] ma_rdata;
  logic        ma_done;
  logic [7:0]  mem_din = 8'd0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  initial forever #5 clk = ~clk;

  mem_port_arbiter #(.MEM_A_BITS(ABits), .IF_BYTES(IfN)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .ma_req(ma_req), .ma_we(ma_we), .ma_width(ma_width), .ma_addr(ma_addr),
    .ma_wdata(ma_wdata), .ma_rdata(ma_rdata), .ma_done(ma_done),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  logic [7:0]  mem [0:(1<<ABits)-1];
  logic [31:0] a_log [0:63];
  int          total = 0, passed = 0;
  int          strobes, stall_strobes, upper_bad, done_bad, if_pulses, ma_pulses;
  logic [31:0] if_seen, ma_seen, exp_if_rdata, exp_ma_rdata;
  bit          ma_known, last_ma, win_ma;
  int          c_if, c_ma, e_if, e_ma;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] maddr(input logic [31:0] a, input int k);
    logic [31:0] t;
    t = (a + 32'(k)) & AMask;
    return t[17:0];
  endfunction

  // One bus cycle: sample mid-cycle, update the memory model, return read data next cycle.
  task automatic tick(input int c);
    logic [7:0] nxt;
    @(negedge clk);
    if (c >= 0 && c < 64) a_log[c] = mem_a;
    if ((mem_a & ~AMask) != 32'd0) upper_bad++;
    if (mem_wr) begin
      strobes++;
      if (!rdy) stall_strobes++;
      mem[mem_a[17:0]] = mem_dout;
    end
    if (!rdy && (if_done || ma_done)) done_bad++;
    if (if_done) begin if_pulses++; if_seen = if_rdata; end
    if (ma_done) begin ma_pulses++; ma_seen = ma_rdata; end
    nxt = mem[mem_a[17:0]];
    @(posedge clk);
    #1 mem_din = nxt;
  endtask

  task automatic txn(input bit is_ma, input bit we, input logic [1:0] width,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input int s, input int l, input string tag);
    int n, lat, exp_lat, p0;
    logic [31:0] exp_rd;
    n = !is_ma ? IfN : (width == 2'b00 ? 1 : (width == 2'b01 ? 2 : 4));
    exp_rd = 32'd0;
    for (int k = 0; k < n; k++) exp_rd |= 32'(mem[maddr(addr, k)]) << (8 * k);
    // A stall over a read with a byte in flight costs one extra re-issue cycle.
    exp_lat = (we ? n + 1 : n + 2) + l + ((!we && l > 0 && s >= 2 && s <= n + 1) ? 1 : 0);
    strobes = 0; stall_strobes = 0; upper_bad = 0; done_bad = 0; if_pulses = 0; ma_pulses = 0;
    if (is_ma) begin
      ma_req = 1'b1; ma_we = we; ma_width = width; ma_addr = addr; ma_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    lat = -1;
    for (int c = 0; c < 64 && lat < 0; c++) begin
      rdy = (l > 0 && c >= s && c < s + l) ? 1'b0 : 1'b1;
      p0 = is_ma ? ma_pulses : if_pulses;
      tick(c);
      if ((is_ma ? ma_pulses : if_pulses) != p0) lat = c;
    end
    rdy = 1'b1; if_req = 1'b0; ma_req = 1'b0;
    tick(-1); tick(-1);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " own done pulses"}, 32'(is_ma ? ma_pulses : if_pulses), 32'd1);
    chk({tag, " other done pulses"}, 32'(is_ma ? if_pulses : ma_pulses), 32'd0);
    chk({tag, " strobes while stalled"}, 32'(stall_strobes), 32'd0);
    chk({tag, " done while stalled"}, 32'(done_bad), 32'd0);
    chk({tag, " upper addr bits"}, 32'(upper_bad), 32'd0);
    if (we) begin
      chk({tag, " write strobes"}, 32'(strobes), 32'(n));
      for (int k = 0; k < n; k++)
        chk({tag, " mem byte"}, 32'(mem[maddr(addr, k)]), 32'(8'(wdata >> (8 * k))));
      ma_known = 1'b0;
    end else begin
      chk({tag, " read strobes"}, 32'(strobes), 32'd0);
      chk({tag, " rdata"}, is_ma ? ma_seen : if_seen, exp_rd);
      if (is_ma) begin exp_ma_rdata = exp_rd; ma_known = 1'b1; end
      else exp_if_rdata = exp_rd;
    end
    if (is_ma) chk({tag, " if_rdata hold"}, if_rdata, exp_if_rdata);
    else if (ma_known) chk({tag, " ma_rdata hold"}, ma_rdata, exp_ma_rdata);
    last_ma = is_ma;
  endtask

  bit          r_ma, r_we;
  logic [1:0]  r_w;
  logic [31:0] r_a, r_d;
  int          r_n, r_s, r_l;

  initial begin
    for (int i = 0; i < (1 << ABits); i++) mem[i] = 8'($urandom);
    #2 rst = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("reset mem_a", mem_a, 32'd0);
    chk("reset mem_wr", 32'(mem_wr), 32'd0);
    chk("reset mem_dout", 32'(mem_dout), 32'd0);
    chk("reset if_rdata", if_rdata, 32'd0);
    chk("reset ma_rdata", ma_rdata, 32'd0);
    chk("reset if_done", 32'(if_done), 32'd0);
    chk("reset ma_done", 32'(ma_done), 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    exp_if_rdata = 32'd0; exp_ma_rdata = 32'd0; ma_known = 1'b1; last_ma = 1'b0;

    // IF word read with known bytes
    mem[18'h10] = 8'h13; mem[18'h11] = 8'h05; mem[18'h12] = 8'h00; mem[18'h13] = 8'h00;
    txn(1'b0, 1'b0, 2'b00, 32'h10, 32'd0, 0, 0, "if_word");
    for (int k = 1; k <= 4; k++) chk("if_word mem_a step", a_log[k], 32'h10 + 32'(k - 1));
    chk("if_word value", if_seen, 32'h0000_0513);

    // MA byte write
    txn(1'b1, 1'b1, 2'b00, 32'h0003_0000, 32'h41, 0, 0, "ma_byte_wr");
    chk("ma_byte_wr mem_a", a_log[1], 32'h0003_0000);

    // Simultaneous requests
    mem[18'h100] = 8'hCD; mem[18'h101] = 8'hAB;
`ifdef ARB_RR_EN
    win_ma = !last_ma;
`else
    win_ma = 1'b1;
`endif
    exp_if_rdata = 32'd0;
    for (int k = 0; k < 4; k++) exp_if_rdata |= 32'(mem[maddr(32'h200, k)]) << (8 * k);
    e_ma = win_ma ? 4 : 7 + 4;
    e_if = win_ma ? 5 + 6 : 6;
    if_pulses = 0; ma_pulses = 0; c_if = -1; c_ma = -1;
    if_req = 1'b1; if_addr = 32'h200;
    ma_req = 1'b1; ma_we = 1'b0; ma_width = 2'b01; ma_addr = 32'h100;
    for (int c = 0; c < 64 && (c_if < 0 || c_ma < 0); c++) begin
      tick(c);
      if (ma_pulses != 0 && c_ma < 0) begin c_ma = c; ma_req = 1'b0; end
      if (if_pulses != 0 && c_if < 0) begin c_if = c; if_req = 1'b0; end
    end
    if_req = 1'b0; ma_req = 1'b0;
    tick(-1); tick(-1);
    chk("both ma done cycle", 32'(c_ma), 32'(e_ma));
    chk("both if done cycle", 32'(c_if), 32'(e_if));
    chk("both ma_rdata", ma_seen, 32'h0000_ABCD);
    chk("both if_rdata", if_seen, exp_if_rdata);
    chk("both pulse count", 32'(if_pulses + ma_pulses), 32'd2);
    exp_ma_rdata = 32'h0000_ABCD; ma_known = 1'b1; last_ma = !win_ma;

    // Word write stalled for 3 cycles after byte 1
    txn(1'b1, 1'b1, 2'b10, 32'h2000, 32'hA1B2_C3D4, 3, 3, "wr_stall");

    // Word read stalled after byte 1 captured
    txn(1'b0, 1'b0, 2'b00, 32'h4000, 32'd0, 4, 3, "rd_stall");
    chk("rd_stall reissue addr", a_log[7], 32'h4002);

    // Address wrap across 2^32 and the MEM_A_BITS mask
    txn(1'b0, 1'b0, 2'b00, 32'hFFFF_FFFE, 32'd0, 0, 0, "if_wrap");
    chk("if_wrap mem_a", a_log[3], 32'h0);

    // Reset in the middle of a word write
    mem[18'h5002] = 8'h00;
    strobes = 0; if_pulses = 0; ma_pulses = 0;
    ma_req = 1'b1; ma_we = 1'b1; ma_width = 2'b10; ma_addr = 32'h5000; ma_wdata = 32'h1122_3344;
    tick(0); tick(1); tick(2);
    chk("rst_mid wr before", 32'(mem_wr), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mid mem_a", mem_a, 32'd0);
    ma_req = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    tick(-1); tick(-1); tick(-1);
    chk("rst_mid done pulses", 32'(ma_pulses + if_pulses), 32'd0);
    chk("rst_mid strobes", 32'(strobes), 32'd2);
    chk("rst_mid byte2 unwritten", 32'(mem[18'h5002]), 32'd0);
    exp_if_rdata = 32'd0; exp_ma_rdata = 32'd0; ma_known = 1'b1; last_ma = 1'b0;
    txn(1'b0, 1'b0, 2'b00, 32'h6000, 32'd0, 0, 0, "post_rst");

    // Randomized single-port transactions
    for (int t = 0; t < 40; t++) begin
      r_ma = 1'($urandom_range(0, 1));
      r_we = r_ma ? 1'($urandom_range(0, 1)) : 1'b0;
      r_w  = 2'($urandom);
      r_a  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3)) : $urandom;
      r_d  = $urandom;
      r_n  = !r_ma ? IfN : (r_w == 2'b00 ? 1 : (r_w == 2'b01 ? 2 : 4));
      r_l  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0;
      r_s  = $urandom_range(0, r_we ? r_n + 1 : r_n + 2);
      txn(r_ma, r_we, r_w, r_a, r_d, r_s, r_l, "random");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the CPU's single byte-wide external memory bus between two requesters: the instruction fetch port (IF) and the memory-access stage port (MA).
- Serialises each granted 1/2/4-byte access into byte transfers on mem_a/mem_din/mem_dout/mem_wr.
- Returns assembled little-endian data together with a one-cycle done pulse.
- Sits between IF/MA and the cpu top-level memory pins; replaces the separate memory control and access path.

Parameters:
- MEM_A_BITS, 18: low bits of mem_a driven from the access address; upper bits forced to 0.
- IF_BYTES, 4: fixed byte count of every IF read (legal values 2 or 4).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- rdy  in  1  global ready; low freezes the block
- if_req  in  1  IF read request, held until if_done
- if_addr  in  32  IF byte address
- if_rdata  out  32  assembled instruction, valid with if_done
- if_done  out  1  one-cycle completion pulse
- ma_req  in  1  MA request, held until ma_done
- ma_we  in  1  1 = write, 0 = read
- ma_width  in  2  00 byte, 01 half, 10/11 word
- ma_addr  in  32  MA byte address
- ma_wdata  in  32  write data; byte i = bits [8i+7:8i]
- ma_rdata  out  32  read data, zero-extended, valid with ma_done
- ma_done  out  1  one-cycle completion pulse
- mem_din  in  8  memory read byte
- mem_dout  out  8  memory write byte
- mem_a  out  32  memory address
- mem_wr  out  1  1 = write strobe

Behaviour:
- Reset (rst low, asynchronous): state IDLE; mem_a, mem_dout, mem_wr, if_rdata, ma_rdata, if_done, ma_done all 0; byte counters 0. Any transfer in progress is aborted with no done pulse. mem_wr drops immediately.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - Samples requests each cycle; request inputs are not sampled in any other state.
  - On grant: latches requester, address, byte count N (1/2/4), write flag and wdata; loads mem_a with the address; moves to READ or WRITE.
  - Grant policy: MA beats IF when both are requesting.
- Memory timing: data for the address presented in cycle n appears on mem_din in cycle n+1.
- READ is pipelined. With the request seen in cycle 0:
  - mem_a = addr+k in cycle k+1, for k = 0..N-1.
  - Byte k is captured at the end of cycle k+2.
  - Done pulse in cycle N+2. Word read latency = 6 cycles; byte read = 3.
- WRITE: mem_wr=1 with mem_a=addr+k and mem_dout=byte k in cycle k+1. Done pulse in cycle N+1.
- DONE:
  - Exactly one done pulse for the granted requester, with rdata stable during the pulse.
  - mem_wr=0; next state IDLE.
  - A requester still asserting req in the following IDLE cycle starts a new transaction, so requesters drop req the cycle after done.
- rdata: byte k goes to bits [8k+7:8k]; unused upper bytes are 0. Output holds until the next done for that port.
- Address arithmetic: addr+k is a 32-bit wrap, then masked to MEM_A_BITS.
- rdy low:
  - All registers hold; mem_wr is gated to 0 combinationally, so no write is duplicated or lost. The pending write byte is issued on the first rdy-high cycle.
  - In READ, the in-flight byte is discarded. On the first rdy-high cycle, mem_a re-presents the first uncaptured address and no capture occurs that cycle.
  - Done is never asserted while rdy is low; a pending done pulse is delayed to the first rdy-high cycle.
- Reads of the I/O region (mem_a[17:16]=11) get no special treatment; byte reads are the requester's responsibility.

Optional Feature:
- ARB_RR_EN defined: round-robin arbitration. A 1-bit last-grant register, reset to IF, gives priority to the port not granted last when both request.
- ARB_RR_EN undefined: fixed MA-over-IF priority and no last-grant register.

Test Plan:
- Reset then IF read of 0x00000010, memory bytes 13,05,00,00 -> mem_a steps 0x10..0x13 in cycles 1..4; if_done in cycle 6 with if_rdata=0x00000513.
- MA byte write: 0x30000, wdata 0x41, width 00 -> a single cycle with mem_wr=1, mem_a=0x30000, mem_dout=0x41; ma_done the next cycle.
- if_req and ma_req (half read at 0x100, bytes 0xCD,0xAB) rise in the same cycle -> MA served first, ma_rdata=0x0000ABCD. IF is then granted in the IDLE after DONE. With ARB_RR_EN and last grant = MA, IF is served first instead.
- rdy low for 3 cycles during a word write after byte 1 -> mem_wr=0 throughout; byte 2 written once after resume; exactly 4 write strobes total.
- rdy low during a word read after byte 1 is captured -> byte-2 address re-presented on resume; if_rdata is correct and done is delayed by 3 cycles plus 1 re-issue cycle.
- rst asserted mid word write -> mem_wr=0 immediately, no done pulse, IDLE after release; a new request proceeds normally.
